// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: StrobeM size codes, FSM state type,
// default timeout and small decode helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] StrobeB  = 3'b000;
    localparam logic [2:0] StrobeH  = 3'b001;
    localparam logic [2:0] StrobeW  = 3'b010;
    localparam logic [2:0] StrobeBu = 3'b100;
    localparam logic [2:0] StrobeHu = 3'b101;

    localparam int unsigned TimeoutCyclesDefault = 255;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic logic strobe_legal(logic [2:0] strobe);
        return (strobe == StrobeB) || (strobe == StrobeH) || (strobe == StrobeW) ||
               (strobe == StrobeBu) || (strobe == StrobeHu);
    endfunction

    // Halfwords must sit on an even address, words on a 4-byte boundary.
    function automatic logic strobe_misaligned(logic [2:0] strobe, logic [1:0] addr_lo);
        return (((strobe == StrobeH) || (strobe == StrobeHu)) && addr_lo[0]) ||
               ((strobe == StrobeW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: store data replication, byte enables, and load
// lane extraction with sign/zero extension.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  strobe,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode the access size into lane masks, replicated store data and load result.
    always_comb begin
        wdata_rep = wdata;
        byte_en   = 4'b0000;
        load_data = '0;
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (strobe)
            StrobeB, StrobeBu: begin
                wdata_rep = {4{wdata[7:0]}};
                byte_en   = 4'b0001 << addr_lo;
                load_data = (strobe == StrobeB) ? {{24{byte_sel[7]}}, byte_sel}
                                                : {24'b0, byte_sel};
            end
            StrobeH, StrobeHu: begin
                wdata_rep = {2{wdata[15:0]}};
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = (strobe == StrobeH) ? {{16{half_sel[15]}}, half_sel}
                                                : {16'b0, half_sel};
            end
            StrobeW: begin
                byte_en   = 4'b1111;
                load_data = rdata;
            end
            default: begin
                wdata_rep = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a pipeline load/store request into a single bus
// transaction, stalling upstream until the access completes, times out or faults.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN makes misaligned H/W accesses fault
// without touching the bus; otherwise they are issued to the enclosing word.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  StrobeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        BusReq,
    output logic        BusWrite,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusByteEn,
    input  logic        BusReady,
    input  logic [31:0] BusRData,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [2:0]       strobe_q;
    logic             write_q, fault_q;
    logic [CntW-1:0]  cnt_q, cnt_inc;

    logic             req, misaligned, bad_access;
    logic             start, done_ok, fault_set;
    logic [31:0]      fmt_wdata, fmt_load;
    logic [3:0]       fmt_be;

    assign req     = MemReadM | MemWriteM;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misaligned = strobe_misaligned(StrobeM, ALUResultM[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Illegal sizes (and trapped misalignment) never reach the bus.
    assign bad_access = !strobe_legal(StrobeM) || misaligned;

    mem_lane_fmt u_lane_fmt (
        .strobe    (strobe_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (BusRData),
        .wdata_rep (fmt_wdata),
        .byte_en   (fmt_be),
        .load_data (fmt_load)
    );

    // Next-state decode; StallM is combinational so the pipeline freezes in the request cycle.
    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        start     = 1'b0;
        done_ok   = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    StallM = 1'b1;
                    start  = 1'b1;
                    if (bad_access) begin
                        state_d   = StDone;
                        fault_set = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                StallM = 1'b1;
                if (BusReady) begin
                    state_d = StDone;
                    done_ok = 1'b1;
                end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                    state_d   = StDone;
                    fault_set = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, request latches, busy-cycle counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_set;
            if (start) begin
                addr_q   <= ALUResultM;
                wdata_q  <= WriteDataM;
                strobe_q <= StrobeM;
                write_q  <= MemWriteM;
                cnt_q    <= '0;
            end
            if (state_q == StBusy) begin
                cnt_q <= cnt_inc;
            end
            if (done_ok) begin
                rdata_q <= write_q ? 32'h0 : fmt_load;
            end
            if (fault_set) begin
                rdata_q <= '0;
            end
        end
    end

    assign BusReq    = (state_q == StBusy);
    assign BusWrite  = write_q;
    assign BusAddr   = {addr_q[31:2], 2'b00};
    assign BusWData  = fmt_wdata;
    assign BusByteEn = BusReq ? fmt_be : 4'b0000;
    assign ReadDataM = rdata_q;
    assign FaultM    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus beats and
// access results; independent monitors pop and compare as the DUT presents them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  StrobeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        BusReq, BusWrite;
    logic [31:0] BusAddr, BusWData;
    logic [3:0]  BusByteEn;
    logic        BusReady;
    logic [31:0] BusRData;
    logic [31:0] ReadDataM;
    logic        StallM, FaultM;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          stall;
        int          reqs;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .StrobeM    (StrobeM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .BusReq     (BusReq),
        .BusWrite   (BusWrite),
        .BusAddr    (BusAddr),
        .BusWData   (BusWData),
        .BusByteEn  (BusByteEn),
        .BusReady   (BusReady),
        .BusRData   (BusRData),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // delay >= 0: BusReady in that BUSY cycle; -1: never ready (timeout); -2: no bus access.
    task automatic access(input logic rd, input logic wr, input logic [2:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                          input logic [31:0] exp_rdata, input logic exp_fault);
        bus_exp_t b;
        res_exp_t r;
        int       k;
        logic     finished;
        @(posedge clk);
        #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        StrobeM    = strb;
        ALUResultM = addr;
        WriteDataM = wdata;
        BusRData   = rdata;
        BusReady   = 1'b0;
        r.rdata = exp_rdata;
        r.fault = exp_fault;
        r.reqs  = (delay >= 0) ? delay + 1 : (delay == -1) ? 4 : 0;
        r.stall = r.reqs + 1;
        res_q.push_back(r);
        if (delay >= 0) begin
            b.addr  = addr & 32'hFFFF_FFFC;
            b.wdata = exp_bwdata;
            b.be    = exp_be;
            b.wr    = wr;
            bus_q.push_back(b);
        end
        k = 0;
        finished = 1'b0;
        for (int i = 0; i < 40 && !finished; i++) begin
            @(posedge clk);
            #1;
            if (!StallM) begin
                finished = 1'b1;
            end else begin
                BusReady = (delay >= 0) && (k == delay);
                k++;
            end
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        BusReady  = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL access_bound: got no completion expected DONE within 40 cycles");
        end
    endtask

    // Bus monitor: checks every completed bus beat against the next expected one.
    initial begin
        bus_exp_t b;
        forever begin
            @(negedge clk);
            if (BusReq === 1'b1 && BusReady === 1'b1) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: got beat at %h expected none", BusAddr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", BusAddr, b.addr);
                    chk("bus_wdata", BusWData, b.wdata);
                    chk("bus_be", 32'(BusByteEn), 32'(b.be));
                    chk("bus_write", 32'(BusWrite), 32'(b.wr));
                end
            end
        end
    end

    // Result monitor: an access ends when StallM falls; check result, fault and timing.
    initial begin
        res_exp_t r;
        int       stall_cnt = 0;
        int       req_cnt = 0;
        logic     stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (StallM === 1'b1) stall_cnt++;
            if (BusReq === 1'b1) req_cnt++;
            if (stall_prev === 1'b1 && StallM === 1'b0) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL res_unexpected: got completion expected none");
                end else begin
                    r = res_q.pop_front();
                    chk("read_data", ReadDataM, r.rdata);
                    chk("fault", 32'(FaultM), 32'(r.fault));
                    chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
                    chk("busreq_cycles", 32'(req_cnt), 32'(r.reqs));
                end
                stall_cnt = 0;
                req_cnt = 0;
            end
            stall_prev = StallM;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        StrobeM = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        BusReady = 1'b0;
        BusRData = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busreq", 32'(BusReq), 32'h0);
        chk("rst_buswrite", 32'(BusWrite), 32'h0);
        chk("rst_busaddr", BusAddr, 32'h0);
        chk("rst_buswdata", BusWData, 32'h0);
        chk("rst_busbe", 32'(BusByteEn), 32'h0);
        chk("rst_readdata", ReadDataM, 32'h0);
        chk("rst_fault", 32'(FaultM), 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);

        //      rd    wr    size    addr          wdata         rdata         dly  be       bwdata        rdata_exp     flt
        access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
        access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
        access(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0,        0, 4'b1111, 32'h1122_3344, 32'h0,        1'b0);
        access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_1234, 2, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
        access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,        0, 4'b1100, 32'h1234_1234, 32'h0,        1'b0);
        access(1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h8001_F234, 0, 4'b0011, 32'h0,        32'h0000_F234, 1'b0);
        access(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 1, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_hold_readdata", ReadDataM, 32'hCAFE_F00D);
        chk("idle_stall", 32'(StallM), 32'h0);

        // Timeout after 4 BUSY cycles, then an illegal size code.
        access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0,        32'h5555_5555, -1, 4'b0000, 32'h0,       32'h0,        1'b1);
        access(1'b1, 1'b0, 3'b011, 32'h0000_0308, 32'h0,        32'h5555_5555, -2, 4'b0000, 32'h0,       32'h0,        1'b1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h1122_3344, -2, 4'b0000, 32'h0,       32'h0,        1'b1);
`else
        access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h1122_3344, 0, 4'b1111, 32'h0,        32'h1122_3344, 1'b0);
`endif

        // Reset in the second BUSY cycle abandons the access.
        begin
            res_exp_t r;
            r.rdata = 32'h0;
            r.fault = 1'b0;
            r.stall = 3;
            r.reqs  = 2;
            res_q.push_back(r);
        end
        @(posedge clk);
        #1;
        MemReadM = 1'b1;
        StrobeM = 3'b010;
        ALUResultM = 32'h0000_0400;
        WriteDataM = 32'h0;
        BusRData = 32'h7777_7777;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        MemReadM = 1'b0;
        @(negedge clk);
        chk("rstbusy_busreq", 32'(BusReq), 32'h0);
        chk("rstbusy_stall", 32'(StallM), 32'h0);
        chk("rstbusy_busaddr", BusAddr, 32'h0);
        chk("rstbusy_buswdata", BusWData, 32'h0);
        chk("rstbusy_busbe", 32'(BusByteEn), 32'h0);
        chk("rstbusy_buswrite", 32'(BusWrite), 32'h0);
        chk("rstbusy_fault", 32'(FaultM), 32'h0);

        // Normal operation resumes after reset.
        access(1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0,        32'h00AB_0000, 0, 4'b0100, 32'h0,        32'hFFFF_FFAB, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        chk("res_q_drained", 32'(res_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
